// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick between IF and LS; rr_ptr_i breaks ties.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic ls_req_i,
  input  logic rr_ptr_i,
  output logic any_req_o,
  output logic win_o
);

  always_comb begin
    any_req_o = if_req_i | ls_req_i;
    win_o     = GNT_LS;
    if (if_req_i && ls_req_i) begin
      win_o = rr_ptr_i;
    end else if (if_req_i) begin
      win_o = GNT_IF;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port Memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise LS wins ties.
module memory_arbiter #(
  parameter int ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_arb_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ready,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);
  import mem_arb_pkg::*;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    sel_ptr;
  logic                    any_req;
  logic                    win;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign sel_ptr = ptr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= GNT_LS;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any_req) begin
      ptr_d = ~win;
    end
  end
`else
  assign sel_ptr = GNT_LS;
`endif

  mem_arb_select u_select (
    .if_req_i  (if_req),
    .ls_req_i  (ls_req),
    .rr_ptr_i  (sel_ptr),
    .any_req_o (any_req),
    .win_o     (win)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= GNT_IF;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Request fields need no reset: outputs are gated by state, which is reset.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          gnt_d   = win;
          we_d    = (win == GNT_LS) ? ls_we : 1'b0;
          addr_d  = (win == GNT_LS) ? ls_addr : if_addr;
          wdata_d = ls_wdata;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    if_ready    = 1'b0;
    ls_ready    = 1'b0;
    if_rdata    = '0;
    ls_rdata    = '0;
    busy        = (state_q != IDLE);
    if (state_q == ACCESS) begin
      mem_read    = ~we_q;
      mem_write   = we_q;
      mem_address = addr_q;
      mem_data_in = wdata_q;
    end
    if (state_q == DONE) begin
      if (gnt_q == GNT_LS) begin
        ls_ready = 1'b1;
        ls_rdata = mem_data_out;
      end else begin
        if_ready = 1'b1;
        if_rdata = mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a word-addressed Memory model.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [7:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  memory_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .ls_req       (ls_req),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_ready     (ls_ready),
    .ls_rdata     (ls_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  // Memory model: 64 words, initial word at byte address A is 0x10000000 | A.
  logic [31:0] mem [64];
  logic        mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 | (i << 2);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_write) mem[mem_address[7:2]] <= mem_data_in;
      if (mem_read)  mem_data_out <= mem[mem_address[7:2]];
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [9];

  logic        exp_gnt [4];
  logic        got_gnt [4];
  int          ngnt;
  logic [31:0] seq_data [3];
  int          k, last_cyc;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h08, 32'h0,         32'h1000_0008};
    vecs[1] = '{1'b1, 1'b1, 8'h14, 32'h0000_0251, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 8'h14, 32'h0,         32'h0000_0251};
    vecs[3] = '{1'b0, 1'b0, 8'h14, 32'h0,         32'h0000_0251};
    vecs[4] = '{1'b1, 1'b0, 8'h30, 32'h0,         32'h1000_0030};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 32'h0,         32'h1000_0000};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 32'hDEAD_BEEF, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 32'h0,         32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 1'b0, 8'hFF, 32'h0,         32'h1000_00FC};

`ifdef MEM_ARB_RR_EN
    exp_gnt = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    seq_data = '{32'hDEAD_BEEF, 32'h1000_0004, 32'h1000_0008};

    reset_n  = 1'b0;
    if_req   = 1'b1;
    if_addr  = 8'h08;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 8'h10;
    ls_wdata = 32'h1234_5678;
    @(negedge clock);
    tick();
    tick();
    check("rst_mem_read",  {31'b0, mem_read},  32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_if_ready",  {31'b0, if_ready},  32'h0);
    check("rst_ls_ready",  {31'b0, ls_ready},  32'h0);
    check("rst_busy",      {31'b0, busy},      32'h0);
    check("rst_mem_addr",  {24'b0, mem_address}, 32'h0);
    check("rst_mem_din",   mem_data_in,        32'h0);
    if_req  = 1'b0;
    ls_req  = 1'b0;
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", {31'b0, busy},     32'h0);
    check("post_rst_rd",   {31'b0, mem_read}, 32'h0);

    // Table: single requester per vector, fields scrambled after grant.
    for (int i = 0; i < 9; i++) begin
      if_req   = !vecs[i].is_ls;
      ls_req   = vecs[i].is_ls;
      ls_we    = vecs[i].we;
      if_addr  = vecs[i].addr;
      ls_addr  = vecs[i].addr;
      ls_wdata = vecs[i].wdata;
      tick();
      if_addr  = ~vecs[i].addr;
      ls_addr  = ~vecs[i].addr;
      ls_wdata = ~vecs[i].wdata;
      ls_we    = ~vecs[i].we;
      check($sformatf("v%0d_acc_rd", i),   {31'b0, mem_read},  {31'b0, ~vecs[i].we});
      check($sformatf("v%0d_acc_wr", i),   {31'b0, mem_write}, {31'b0, vecs[i].we});
      check($sformatf("v%0d_acc_addr", i), {24'b0, mem_address}, {24'b0, vecs[i].addr});
      if (vecs[i].we) check($sformatf("v%0d_acc_din", i), mem_data_in, vecs[i].wdata);
      check($sformatf("v%0d_acc_busy", i), {31'b0, busy}, 32'h1);
      check($sformatf("v%0d_acc_rdy", i),  {30'b0, if_ready, ls_ready}, 32'h0);
      tick();
      check($sformatf("v%0d_done_strb", i), {30'b0, mem_read, mem_write}, 32'h0);
      check($sformatf("v%0d_done_rdy", i),  {30'b0, if_ready, ls_ready},
            vecs[i].is_ls ? 32'h1 : 32'h2);
      if (!vecs[i].we)
        check($sformatf("v%0d_rdata", i), vecs[i].is_ls ? ls_rdata : if_rdata, vecs[i].rdata);
      if_req = 1'b0;
      ls_req = 1'b0;
      tick();
      check($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 32'h0);
    end

    // Both requesters held: grant order.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    if_req  = 1'b1;
    if_addr = 8'h08;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 8'h04;
    ngnt    = 0;
    for (int c = 0; c < 20 && ngnt < 4; c++) begin
      tick();
      check("excl_strobes", {31'b0, mem_read & mem_write}, 32'h0);
      if (if_ready || ls_ready) begin
        check("single_ready", {31'b0, if_ready & ls_ready}, 32'h0);
        got_gnt[ngnt] = ls_ready;
        ngnt++;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    check("tie_grant_count", ngnt, 4);
    for (int g = 0; g < ngnt && g < 4; g++)
      check($sformatf("tie_grant%0d_is_ls", g), {31'b0, got_gnt[g]}, {31'b0, exp_gnt[g]});

    // Reset during ACCESS of an LS write.
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 8'h1C;
    ls_wdata = 32'h0000_C0DE;
    tick();
    check("rmid_acc_wr", {31'b0, mem_write}, 32'h1);
    reset_n = 1'b0;
    tick();
    check("rmid_busy",     {31'b0, busy},      32'h0);
    check("rmid_ls_ready", {31'b0, ls_ready},  32'h0);
    check("rmid_mem_wr",   {31'b0, mem_write}, 32'h0);
    check("rmid_written",  mem[7],             32'h0000_C0DE);
    reset_n = 1'b1;
    tick();
    check("rmid_regrant_wr",   {31'b0, mem_write},   32'h1);
    check("rmid_regrant_addr", {24'b0, mem_address}, 32'h1C);
    tick();
    check("rmid_regrant_rdy", {31'b0, ls_ready}, 32'h1);
    ls_req = 1'b0;
    tick();

    // IF held across back-to-back reads.
    if_req   = 1'b1;
    if_addr  = 8'h00;
    k        = 0;
    last_cyc = 0;
    for (int c = 1; c <= 30 && k < 3; c++) begin
      tick();
      if (if_ready) begin
        check($sformatf("b2b_data%0d", k), if_rdata, seq_data[k]);
        if (k > 0) check($sformatf("b2b_gap%0d", k), c - last_cyc, 3);
        last_cyc = c;
        k++;
        if_addr = 8'(k * 4);
      end
    end
    if_req = 1'b0;
    check("b2b_count", k, 3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
